core_scheduler: RTL and testbench
=================================

CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 SHALL have parameter NCORES, default 4, number of RC4 decrypt cores served.
REQ-002 SHALL have parameter KEY_W, default 24, width of the secret-key search space.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a key search.
REQ-006 SHALL have port core_ready  input  NCORES  bit i high when core i is idle and can accept a key.
REQ-007 SHALL have port core_done  input  NCORES  one-cycle pulse per core, result valid.
REQ-008 SHALL have port core_found  input  NCORES  bit i qualified by core_done[i]; high means the key decrypted to valid text.
REQ-009 SHALL have port core_start  output  NCORES  one-hot, one-cycle dispatch pulse.
REQ-010 SHALL have port core_key  output  KEY_W  shared key bus, valid only while core_start is non-zero.
REQ-011 SHALL have port core_abort  output  1  one-cycle pulse telling all cores to drop work.
REQ-012 SHALL have port busy, done, found  output  1 each  search status.
REQ-013 SHALL have port found_key  output  KEY_W  winning key, valid when found is high.

Function
REQ-014 SHALL implement FSM states IDLE, DISPATCH, DRAIN, ABORT, DONE.
REQ-015 IDLE: start -> DISPATCH, next_key cleared to 0, done/found cleared; start in any other state ignored.
REQ-016 DISPATCH: each cycle, at most one core granted, round-robin over ready cores starting after the last grant (first grant after start goes to lowest ready index).
REQ-017 A grant SHALL drive core_start[i]=1 and core_key=next_key in the same cycle, record next_key in per-core register key_q[i], and increment next_key.
REQ-018 A core granted in cycle t SHALL NOT be granted again before it pulses core_done, regardless of core_ready.
REQ-019 After dispatching key 2^KEY_W-1 the counter SHALL set an exhausted flag (no wrap to 0) and the FSM SHALL go to DRAIN.
REQ-020 DRAIN: no dispatches; when no core is outstanding -> DONE with found=0.
REQ-021 Any core_done[i] with core_found[i] in DISPATCH or DRAIN -> ABORT, found_key=key_q[i], found=1 next cycle.
REQ-022 Simultaneous found pulses from several cores: lowest index wins.
REQ-023 A found pulse in the same cycle as a dispatch: the dispatch still occurs; ABORT follows.
REQ-024 ABORT: core_abort=1 for exactly one cycle, all outstanding flags cleared, -> DONE.
REQ-025 DONE: done=1 sticky, found/found_key held; start -> DISPATCH as in REQ-015.
REQ-026 busy SHALL be 1 exactly in DISPATCH, DRAIN, ABORT.
REQ-027 core_done from a core not outstanding, or in IDLE/DONE, SHALL be ignored.
REQ-028 Outputs SHALL be registered; core_start/core_key SHALL be decoded from state and grant with no combinational path from core_done to core_start.

Reset
REQ-029 rst SHALL asynchronously force IDLE; core_start=0, core_key=0, core_abort=0, busy=0, done=0, found=0, found_key=0, next_key=0, exhausted=0, outstanding=0, round-robin pointer=NCORES-1.
REQ-030 rst asserted mid-search SHALL abandon the search without pulsing core_abort; cores are reset by the same rst.

Structure
REQ-031 Shared package rc4_pkg SHALL hold the state enum, default NCORES and KEY_W, and the valid-text character range constants used by cores.
REQ-032 Round-robin grant logic SHALL be one sub-module rr_arbiter (request, pointer in; one-hot grant out).

Verification
REQ-033 KEY_W=4, all ready, no found -> 16 dispatches keys 0..15 in order cores 0,1,2,3,0,...; after last done, done=1, found=0.
REQ-034 Core 2 returns found for key 6 -> core_abort one cycle, found=1, found_key=6, no further core_start.
REQ-035 Cores 1 and 3 both return found in the same cycle (keys 9, 11) -> found_key=9.
REQ-036 core_ready[1]=0 throughout -> keys dispatched only to cores 0,2,3; every key 0..15 issued exactly once.
REQ-037 rst asserted after key 5 dispatched -> next cycle all outputs zero, state IDLE; new start restarts from key 0.
REQ-038 start pulsed while busy -> ignored, dispatch sequence unchanged.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search scheduler and its decrypt cores.
package rc4_pkg;

  localparam int DEF_NCORES = 4;
  localparam int DEF_KEY_W  = 24;

  // Plaintext counts as valid when every byte is a lowercase letter or a space.
  localparam logic [7:0] TEXT_LO    = 8'h61;
  localparam logic [7:0] TEXT_HI    = 8'h7A;
  localparam logic [7:0] TEXT_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_ABORT,
    ST_DONE
  } sched_state_t;

  function automatic logic is_text_char(input logic [7:0] c);
    return ((c >= TEXT_LO) && (c <= TEXT_HI)) || (c == TEXT_SPACE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches requests starting just after the last-granted index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % N);
      if (i_req[w_idx] && (o_grant == '0)) o_grant[w_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Hands out sequential RC4 candidate keys to a pool of decrypt cores and
// collects the first key that yields valid text.
module core_scheduler
  import rc4_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int KEY_W  = DEF_KEY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NCORES-1:0] core_ready,
  input  logic [NCORES-1:0] core_done,
  input  logic [NCORES-1:0] core_found,
  output logic [NCORES-1:0] core_start,
  output logic [KEY_W-1:0]  core_key,
  output logic              core_abort,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [KEY_W-1:0]  found_key
);

  localparam int              IDX_W   = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [KEY_W-1:0] KEY_MAX = '1;

  sched_state_t      r_state, w_state_nxt;
  logic [KEY_W-1:0]  r_next_key;
  logic              r_exhausted;
  logic [NCORES-1:0] r_outstanding;
  logic [IDX_W-1:0]  r_ptr;
  logic [KEY_W-1:0]  r_key_q [NCORES];

  logic [NCORES-1:0] r_core_start;
  logic [KEY_W-1:0]  r_core_key, r_found_key;
  logic              r_core_abort, r_busy, r_done, r_found;

  logic [NCORES-1:0] w_req, w_grant, w_done_vld, w_found_vld;
  logic              w_hit, w_start_go, w_searching;
  logic [IDX_W-1:0]  w_hit_idx, w_grant_idx;

  assign w_searching = (r_state == ST_DISPATCH) || (r_state == ST_DRAIN);
  assign w_start_go  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // Results only count from cores we are actually waiting on.
  assign w_done_vld  = w_searching ? (core_done & r_outstanding) : '0;
  assign w_found_vld = w_done_vld & core_found;
  assign w_req       = ((r_state == ST_DISPATCH) && !r_exhausted) ?
                       (core_ready & ~r_outstanding) : '0;

  rr_arbiter #(.N(NCORES), .IDX_W(IDX_W)) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_grant_idx = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (w_found_vld[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (w_grant[i]) w_grant_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_DISPATCH;
      ST_DISPATCH: begin
        if (w_hit)                                   w_state_nxt = ST_ABORT;
        else if ((|w_grant) && (r_next_key == KEY_MAX)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_hit)                     w_state_nxt = ST_ABORT;
        else if (r_outstanding == '0)  w_state_nxt = ST_DONE;
      end
      ST_ABORT: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_next_key    <= '0;
      r_exhausted   <= 1'b0;
      r_outstanding <= '0;
      r_ptr         <= IDX_W'(NCORES - 1);
      r_core_start  <= '0;
      r_core_key    <= '0;
      r_core_abort  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_found_key   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_core_start <= w_grant;
      r_core_key   <= (|w_grant) ? r_next_key : '0;
      r_core_abort <= (w_state_nxt == ST_ABORT);
      r_busy       <= (w_state_nxt == ST_DISPATCH) || (w_state_nxt == ST_DRAIN) ||
                      (w_state_nxt == ST_ABORT);
      if (w_start_go) begin
        r_next_key    <= '0;
        r_exhausted   <= 1'b0;
        r_outstanding <= '0;
        r_ptr         <= IDX_W'(NCORES - 1);
        r_done        <= 1'b0;
        r_found       <= 1'b0;
      end else begin
        if (|w_grant) begin
          r_ptr <= w_grant_idx;
          // Saturate on the last key so the search space is never revisited.
          if (r_next_key == KEY_MAX) r_exhausted <= 1'b1;
          else                       r_next_key  <= r_next_key + 1'b1;
        end
        if (r_state == ST_ABORT) r_outstanding <= '0;
        else                     r_outstanding <= (r_outstanding & ~w_done_vld) | w_grant;
        if (w_hit) begin
          r_found     <= 1'b1;
          r_found_key <= r_key_q[w_hit_idx];
        end
        if (w_state_nxt == ST_DONE) r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCORES; i++) begin
      if (w_grant[i]) r_key_q[i] <= r_next_key;
    end
  end

  assign core_start = r_core_start;
  assign core_key   = r_core_key;
  assign core_abort = r_core_abort;
  assign busy       = r_busy;
  assign done       = r_done;
  assign found      = r_found;
  assign found_key  = r_found_key;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler with a small behavioural model of the decrypt cores.
module tb_core_scheduler;

  localparam int NC = 4;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [NC-1:0] core_ready, core_done, core_found, core_start;
  logic [KW-1:0] core_key, found_key;
  logic          core_abort, busy, done, found;

  core_scheduler #(.NCORES(NC), .KEY_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .core_ready(core_ready), .core_done(core_done), .core_found(core_found),
    .core_start(core_start), .core_key(core_key), .core_abort(core_abort),
    .busy(busy), .done(done), .found(found), .found_key(found_key)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Core model: fixed latency per key, answers found for the chosen hit keys.
  int hit_a = -1, hit_b = -1, slow_key = -1, slow_extra = 0;
  int lat_base = 3;
  int cnt[NC];
  int kq[NC];

  always @(negedge clk) begin
    if (rst) begin
      core_done  = '0;
      core_found = '0;
      for (int i = 0; i < NC; i++) cnt[i] = 0;
    end else begin
      core_done  = '0;
      core_found = '0;
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          checks++;
          if (cnt[i] != 0) begin
            errors++;
            $display("FAIL regrant core %0d: still busy with key %0d, got key %0d", i, kq[i], core_key);
          end
        end
        if (cnt[i] == 1) begin
          core_done[i]  = 1'b1;
          core_found[i] = (kq[i] == hit_a) || (kq[i] == hit_b);
          cnt[i] = 0;
        end else if (cnt[i] > 1) begin
          cnt[i]--;
        end
        if (core_start[i]) begin
          kq[i]  = int'(core_key);
          cnt[i] = lat_base + ((kq[i] == slow_key) ? slow_extra : 0);
        end
      end
      if (core_abort) begin
        core_done  = '0;
        core_found = '0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
      end
    end
  end

  typedef struct {
    logic [NC-1:0] ready;
    int            hit_a;
    int            hit_b;
    int            slow_key;
    int            slow_extra;
    int            restart_at;
    bit            rr;
    bit            exp_found;
    int            exp_fk;
    int            exp_ndisp;
    int            exp_abort;
  } scn_t;

  scn_t tbl[7];

  task automatic run_scn(input int s);
    int  cyc, ndisp, nabort, abort_cyc, gi;
    bit  fin;
    cyc = 0; ndisp = 0; nabort = 0; abort_cyc = -1; fin = 1'b0;
    @(negedge clk);
    hit_a      = tbl[s].hit_a;
    hit_b      = tbl[s].hit_b;
    slow_key   = tbl[s].slow_key;
    slow_extra = tbl[s].slow_extra;
    core_ready = tbl[s].ready;
    start      = 1'b1;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == tbl[s].restart_at);
      if (cyc == 1) begin
        chk($sformatf("s%0d busy after start", s), busy, 1);
        chk($sformatf("s%0d done cleared", s), done, 0);
        chk($sformatf("s%0d found cleared", s), found, 0);
      end
      if (core_abort) begin
        nabort++;
        abort_cyc = cyc;
      end
      if (core_start != '0) begin
        chk($sformatf("s%0d onehot", s), $onehot(core_start), 1);
        gi = 0;
        for (int i = 0; i < NC; i++) if (core_start[i]) gi = i;
        chk($sformatf("s%0d key order", s), core_key, ndisp);
        chk($sformatf("s%0d grant to ready core", s), tbl[s].ready[gi], 1);
        if (tbl[s].rr) chk($sformatf("s%0d rr core for key %0d", s, ndisp), gi, ndisp % NC);
        if (abort_cyc >= 0 && cyc > abort_cyc) chk($sformatf("s%0d dispatch after abort", s), core_start, 0);
        ndisp++;
      end
      if (done) fin = 1'b1;
    end
    if (!fin) begin
      errors++; checks++;
      $display("FAIL s%0d timeout: done=%0d after %0d cycles, required 1", s, done, cyc);
    end
    chk($sformatf("s%0d found", s), found, tbl[s].exp_found);
    if (tbl[s].exp_found) chk($sformatf("s%0d found_key", s), found_key, tbl[s].exp_fk);
    chk($sformatf("s%0d abort pulses", s), nabort, tbl[s].exp_abort);
    if (tbl[s].exp_ndisp >= 0) chk($sformatf("s%0d dispatch count", s), ndisp, tbl[s].exp_ndisp);
    chk($sformatf("s%0d busy at done", s), busy, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (core_start != '0 || core_abort) begin
        checks++; errors++;
        $display("FAIL s%0d quiet after done: core_start=%0d core_abort=%0d, required 0", s, core_start, core_abort);
      end
    end
    chk($sformatf("s%0d done sticky", s), done, 1);
  endtask

  initial begin
    int seen;
    tbl[0] = '{4'hF,    -1, -1, -1, 0, -1, 1'b1, 1'b0,  0, 16, 0};
    tbl[1] = '{4'hF,     6, -1, -1, 0, -1, 1'b1, 1'b1,  6, -1, 1};
    tbl[2] = '{4'hF,     9, 11,  9, 2, -1, 1'b0, 1'b1,  9, -1, 1};
    tbl[3] = '{4'b1101, -1, -1, -1, 0, -1, 1'b0, 1'b0,  0, 16, 0};
    tbl[4] = '{4'hF,    -1, -1, -1, 0,  6, 1'b1, 1'b0,  0, 16, 0};
    tbl[5] = '{4'hF,     0, -1, -1, 0, -1, 1'b1, 1'b1,  0, -1, 1};
    tbl[6] = '{4'hF,    15, -1, -1, 0, -1, 1'b1, 1'b1, 15, 16, 1};

    rst = 1'b1; start = 1'b0; core_ready = '1;
    repeat (2) @(negedge clk);
    chk("reset core_start", core_start, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset found_key", found_key, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", busy, 0);

    for (int s = 0; s < 7; s++) run_scn(s);

    // Reset in the middle of a search, just after key 5 goes out.
    @(negedge clk);
    hit_a = -1; hit_b = -1; slow_key = -1; core_ready = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      if (core_start != '0 && core_key == KW'(5)) seen = 1;
      else @(negedge clk);
    end
    chk("mid-search key 5 reached", seen, 1);
    rst = 1'b1;
    #1;
    chk("async reset core_start", core_start, 0);
    chk("async reset found_key", found_key, 0);
    @(negedge clk);
    chk("reset core_key", core_key, 0);
    chk("reset core_abort", core_abort, 0);
    chk("reset busy mid", busy, 0);
    chk("reset done mid", done, 0);
    chk("reset found mid", found, 0);
    @(negedge clk);
    chk("reset no abort pulse", core_abort, 0);
    rst = 1'b0;

    run_scn(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
